// File: rtl/add16_pkg.sv
// add16_pkg: shared constants and types for the add16 datapath adder.
//   WORD_W  - operand/result width
//   SLICE_W - width of one ripple-carry slice
//   word_t  - 16-bit operand/result vector
package add16_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned SLICE_W = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage : add16_pkg

// File: rtl/add16_slice4.sv
// add16_slice4: 4-bit ripple-carry slice built from four full adders.
// Ports:
//   a, b  - 4-bit operand nibbles
//   cin   - carry into bit 0 of the slice
//   sum   - 4-bit nibble sum
//   cout  - carry out of bit 3
//   c3    - carry into bit 3 (used for signed-overflow detection)
module add16_slice4
  import add16_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
  end

  assign cout = c[SLICE_W];
  assign c3   = c[SLICE_W-1];

endmodule : add16_slice4

// File: rtl/add16.sv
// add16: 16-bit ripple-carry adder with carry-in/carry-out and a registered
// copy of the result for pipelined consumers.
// Ports:
//   clk     - rising-edge clock for the result register
//   rst_n   - asynchronous active-low reset (clears registered outputs only)
//   en      - load enable for the result register
//   a, b    - operands
//   cin     - carry-in
//   sum     - combinational (a + b + cin) mod 2^WIDTH
//   cout    - combinational carry out of the MSB
//   sum_q   - registered sum
//   cout_q  - registered cout
// Optional (macro ADD16_FLAGS_EN):
//   zero/zero_q - sum == 0
//   neg/neg_q   - sum MSB
//   ovf/ovf_q   - signed overflow (carry into MSB xor carry out of MSB)
module add16
  import add16_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef ADD16_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             zero_q,
  output logic             neg_q,
  output logic             ovf_q
`endif
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  logic [NSLICE:0]   carry;
  logic [NSLICE-1:0] c3;

  assign carry[0] = cin;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    add16_slice4 u_slice (
      .a    (a[k*SLICE_W +: SLICE_W]),
      .b    (b[k*SLICE_W +: SLICE_W]),
      .cin  (carry[k]),
      .sum  (sum[k*SLICE_W +: SLICE_W]),
      .cout (carry[k+1]),
      .c3   (c3[k])
    );
  end

  assign cout = carry[NSLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

`ifdef ADD16_FLAGS_EN
  assign zero = (sum == '0);
  assign neg  = sum[WIDTH-1];
  // Carry into the MSB is the top slice's internal c3.
  assign ovf  = c3[NSLICE-1] ^ carry[NSLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      zero_q <= zero;
      neg_q  <= neg;
      ovf_q  <= ovf;
    end
  end
`else
  // Without flags the per-slice c3 taps have no consumer.
  logic unused_c3;
  assign unused_c3 = ^c3;
`endif

endmodule : add16

// File: tb/tb_add16.sv
// tb_add16: directed self-checking bench for add16 (combinational path,
// registered path, async reset, optional ADD16_FLAGS_EN flags).
module tb_add16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] sum_q;
  logic        cout_q;
`ifdef ADD16_FLAGS_EN
  logic        zero, neg, ovf, zero_q, neg_q, ovf_q;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  add16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
`ifdef ADD16_FLAGS_EN
    ,
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf),
    .zero_q (zero_q),
    .neg_q  (neg_q),
    .ovf_q  (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[10] = '{
    '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0},
    '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0},
    '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0},
    '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0},
    '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1},
    '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1},
    '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0}
  };

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    check("reset_sum_q",  {1'b0, sum_q}, 17'h00000);
    check("reset_cout_q", {16'h0, cout_q}, 17'h00000);
    #10;
    rst_n = 1'b1;

    // Combinational vectors
    foreach (vecs[i]) begin
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      #1;
      check($sformatf("comb_%0d", i), {cout, sum}, {vecs[i].cout, vecs[i].sum});
    end
    // Extra wrap-around corner
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; #1;
    check("comb_ffff_ffff_1", {cout, sum}, 17'h1FFFF);

    // Registered path: load then hold
    @(negedge clk);
    a = 16'hABCD; b = 16'h1234; cin = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check("reg_load_sum_q",  {1'b0, sum_q}, 17'h0BE01);
    check("reg_load_cout_q", {16'h0, cout_q}, 17'h00000);
    @(negedge clk);
    en = 1'b0; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    check("reg_hold_sum_q", {1'b0, sum_q}, 17'h0BE01);
    check("hold_comb_sum",  {cout, sum}, 17'h00002);

    // Async reset between edges, with en high so a clock would otherwise load
    #2;
    en    = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum_q",  {1'b0, sum_q}, 17'h00000);
    check("async_rst_cout_q", {16'h0, cout_q}, 17'h00000);
    check("rst_comb_sum",     {cout, sum}, 17'h00002);
    @(posedge clk); #1;
    check("rst_held_sum_q", {1'b0, sum_q}, 17'h00000);

    // Release and load a carry-out result on first enabled edge
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    @(posedge clk); #1;
    check("post_rst_sum_q",  {1'b0, sum_q}, 17'h00000);
    check("post_rst_cout_q", {16'h0, cout_q}, 17'h00001);

`ifdef ADD16_FLAGS_EN
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    #1;
    check("flg_7fff_sum",  {cout, sum}, 17'h08000);
    check("flg_7fff_ovf",  {16'h0, ovf},  17'h1);
    check("flg_7fff_neg",  {16'h0, neg},  17'h1);
    check("flg_7fff_zero", {16'h0, zero}, 17'h0);
    @(posedge clk); #1;
    check("flg_7fff_q", {14'h0, zero_q, neg_q, ovf_q}, 17'h3);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001;
    #1;
    check("flg_ffff_zero", {16'h0, zero}, 17'h1);
    check("flg_ffff_ovf",  {16'h0, ovf},  17'h0);
    @(posedge clk); #1;
    check("flg_ffff_q", {14'h0, zero_q, neg_q, ovf_q}, 17'h4);
    @(negedge clk);
    a = 16'h8000; b = 16'h8000;
    #1;
    check("flg_8000_sum", {cout, sum}, 17'h10000);
    check("flg_8000_ovf", {16'h0, ovf}, 17'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("flg_rst_q", {14'h0, zero_q, neg_q, ovf_q}, 17'h0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add16
